// File: rtl/module_keypad_scanner_pkg.sv
// pkg_keypad: keypad geometry, key encoding table and scanner state type
package pkg_keypad;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  typedef enum logic [1:0] {SCAN, CONFIRM, RELEASE} scan_state_t;
  function automatic logic [1:0] low_index(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/module_sync_2ff.sv
// module_sync_2ff: two-flop synchronizer for asynchronous inputs
module module_sync_2ff #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/module_keypad_scanner.sv
// module_keypad_scanner: 4x4 keypad column scan, debounce, encode and valid/ready hand-off
module module_keypad_scanner
  import pkg_keypad::*;
#(
  parameter int SCAN_TICKS = 27000,
  parameter int DB_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [3:0]        key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_overrun
);
  localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DB_SAMPLES + 1);
  logic [N_ROWS-1:0] rows;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] col_q, col_d, row_q, row_d;
  scan_state_t state_q, state_d;
  logic [3:0] code_q, code_d;
  logic valid_q, valid_d, ovr_q, ovr_d;
  logic sample, single, none, same, done, emit, accept;
  module_sync_2ff #(.W(N_ROWS)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(row_in),
    .q(rows)
  );
  always_comb begin
    sample = tick_q == TW'(SCAN_TICKS - 1);
    tick_d = sample ? '0 : tick_q + 1'b1;
    single = $onehot(~rows);
    none = &rows;
    same = single && low_index(rows) == row_q;
    cnt_inc = cnt_q + 1'b1;
    done = cnt_inc == CW'(DB_SAMPLES);
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    emit = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (single) begin
            row_d = low_index(rows);
            cnt_d = CW'(1);
            state_d = CONFIRM;
          end else col_d = col_q + 1'b1;
        end
        CONFIRM: begin
          if (!same) begin
            state_d = SCAN;
            col_d = col_q + 1'b1;
          end else if (done) begin
            emit = 1'b1;
            cnt_d = '0;
            state_d = RELEASE;
          end else cnt_d = cnt_inc;
        end
        RELEASE: begin
          cnt_d = none && !done ? cnt_inc : '0;
          if (none && done) begin
            state_d = SCAN;
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    accept = emit && (!valid_q || key_ready);
    code_d = accept ? KEY_MAP[{row_q, col_q}] : code_q;
    valid_d = accept || (valid_q && !key_ready);
    ovr_d = emit && valid_q && !key_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      cnt_q <= '0;
      col_q <= '0;
      row_q <= '0;
      state_q <= SCAN;
      code_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      state_q <= state_d;
      code_q <= code_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign col_out = ~(N_COLS'(1) << col_q);
  assign key_code = code_q;
  assign key_valid = valid_q;
  assign key_overrun = ovr_q;
endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb_module_keypad_scanner: directed checks of scanning, debounce, encoding and handshake
module tb_module_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic key_valid;
  logic key_ready = 1'b1;
  logic key_overrun;
  logic pressed = 1'b0;
  logic multi = 1'b0;
  logic [1:0] prow = '0;
  logic [1:0] pcol = '0;
  logic kv_prev = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int rises = 0;
  int ovr_cycles = 0;
  int base;
  int bad;
  module_keypad_scanner #(.SCAN_TICKS(4), .DB_SAMPLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_overrun(key_overrun)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] strobe(input int n);
    return ~(4'b1 << n);
  endfunction
  always_comb row_in = multi ? 4'b0011 : (pressed && col_out == strobe(int'(pcol))) ? strobe(int'(prow)) : 4'hF;
  always @(negedge clk) begin
    if (key_valid && !kv_prev) rises++;
    kv_prev = key_valid;
    if (key_overrun) ovr_cycles++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (col_out == c && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (col_out != c && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_col", col_out, c);
  endtask
  task automatic press_at(input logic [1:0] r, input logic [1:0] c);
    wait_col(strobe(int'(c)));
    prow = r;
    pcol = c;
    pressed = 1'b1;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, key_valid, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("rotate_%0d", i), col_out, strobe((i / 4) % 4));
    end
    base = rises;
    press_at(2'd1, 2'd2);
    bad = 0;
    repeat (11) begin
      @(negedge clk);
      if (key_valid) bad++;
    end
    chk("clean_early", bad, 0);
    @(negedge clk);
    chk("clean_valid", key_valid, 1);
    chk("clean_code", key_code, 4'h6);
    chk("clean_col_held", col_out, 4'b1011);
    @(negedge clk);
    chk("clean_valid_drop", key_valid, 0);
    repeat (40) @(negedge clk);
    chk("clean_one_pulse", rises - base, 1);
    chk("clean_release_held", col_out, 4'b1011);
    pressed = 1'b0;
    bad = 0;
    while (col_out == 4'b1011 && bad < 40) begin
      @(negedge clk);
      bad++;
    end
    chk("clean_resume", col_out, 4'b0111);
    base = rises;
    press_at(2'd3, 2'd1);
    repeat (9) @(negedge clk);
    pressed = 1'b0;
    repeat (2) @(negedge clk);
    chk("bounce_held", col_out, 4'b1101);
    @(negedge clk);
    chk("bounce_resume", col_out, 4'b1011);
    chk("bounce_no_valid", rises - base, 0);
    press_at(2'd3, 2'd1);
    wait_valid("bounce3_valid");
    chk("bounce3_code", key_code, 4'h0);
    pressed = 1'b0;
    repeat (40) @(negedge clk);
    base = rises;
    multi = 1'b1;
    wait_col(4'b1110);
    repeat (4) @(negedge clk);
    chk("multi_rotate", col_out, 4'b1101);
    repeat (36) @(negedge clk);
    chk("multi_no_valid", rises - base, 0);
    multi = 1'b0;
    key_ready = 1'b0;
    press_at(2'd0, 2'd3);
    wait_valid("bp_valid");
    chk("bp_code", key_code, 4'hA);
    pressed = 1'b0;
    repeat (40) @(negedge clk);
    chk("bp_valid_held", key_valid, 1);
    chk("bp_code_held", key_code, 4'hA);
    base = ovr_cycles;
    press_at(2'd1, 2'd1);
    bad = 0;
    while (ovr_cycles == base && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    chk("bp_overrun_seen", ovr_cycles - base, 1);
    repeat (3) @(negedge clk);
    chk("bp_overrun_once", ovr_cycles - base, 1);
    chk("bp_code_kept", key_code, 4'hA);
    chk("bp_valid_kept", key_valid, 1);
    pressed = 1'b0;
    repeat (40) @(negedge clk);
    chk("bp_no_repeat", ovr_cycles - base, 1);
    key_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain", key_valid, 0);
    press_at(2'd2, 2'd1);
    repeat (5) @(negedge clk);
    chk("midrst_col_held", col_out, 4'b1101);
    rst = 1'b1;
    pressed = 1'b0;
    @(negedge clk);
    chk("midrst_col", col_out, 4'b1110);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_code", key_code, 0);
    rst = 1'b0;
    base = rises;
    repeat (60) @(negedge clk);
    chk("midrst_no_valid", rises - base, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
